// File: rtl/rx_cp_deserializer.sv
// Receive-side deserializer: gathers one OFDM symbol of interleaved I/Q words,
// strips the cyclic prefix, checks it against the symbol tail and hands the symbol off.
module rx_cp_deserializer #(
    parameter int DATA_W = 16,
    parameter int N_FFT  = 8,
    parameter int CP_LEN = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [N_FFT*DATA_W-1:0] out_phase,
    output logic [N_FFT*DATA_W-1:0] out_quad,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    cp_ok,
    output logic                    frame_err,
    output logic [7:0]              sym_count
);

    localparam int FRAME_W = 2 * (CP_LEN + N_FFT);
    localparam int WCNT_W  = $clog2(FRAME_W);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_W - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
    logic [N_FFT*DATA_W-1:0]   phase_q, phase_d;
    logic [N_FFT*DATA_W-1:0]   quad_q, quad_d;
    logic [CP_LEN*DATA_W-1:0]  cpi_q, cpi_d;
    logic [CP_LEN*DATA_W-1:0]  cpq_q, cpq_d;
    logic                      cp_ok_q, cp_ok_d;
    logic                      frame_err_q, frame_err_d;
    logic [7:0]                sym_count_q, sym_count_d;
    logic                      beat_s;
    logic                      at_last_s;
    int                        sample_s;

    // Prefix sample j must repeat useful sample N_FFT-CP_LEN+j on both rails.
    function automatic logic cp_match(
        input logic [CP_LEN*DATA_W-1:0] ci,
        input logic [CP_LEN*DATA_W-1:0] cq,
        input logic [N_FFT*DATA_W-1:0]  ph,
        input logic [N_FFT*DATA_W-1:0]  qd
    );
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < CP_LEN; j++) begin
            ok = ok && (ci[j*DATA_W +: DATA_W] == ph[(N_FFT-CP_LEN+j)*DATA_W +: DATA_W])
                    && (cq[j*DATA_W +: DATA_W] == qd[(N_FFT-CP_LEN+j)*DATA_W +: DATA_W]);
        end
        return ok;
    endfunction

    // Next-state: word routing, frame alignment check and hand-off.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        phase_d     = phase_q;
        quad_d      = quad_q;
        cpi_d       = cpi_q;
        cpq_d       = cpq_q;
        cp_ok_d     = cp_ok_q;
        frame_err_d = 1'b0;
        sym_count_d = sym_count_q;
        beat_s      = in_valid && (state_q == ST_COLLECT);
        at_last_s   = (wcnt_q == LAST_WORD);
        sample_s    = int'(wcnt_q[WCNT_W-1:1]);
        case (state_q)
            ST_COLLECT: begin
                if (beat_s) begin
                    if (in_last != at_last_s) begin
                        // Misaligned terminator: drop this word and resynchronise.
                        frame_err_d = 1'b1;
                        wcnt_d      = '0;
                    end else begin
                        if (sample_s < CP_LEN) begin
                            if (wcnt_q[0]) begin
                                cpq_d[sample_s*DATA_W +: DATA_W] = in_data;
                            end else begin
                                cpi_d[sample_s*DATA_W +: DATA_W] = in_data;
                            end
                        end else begin
                            if (wcnt_q[0]) begin
                                quad_d[(sample_s-CP_LEN)*DATA_W +: DATA_W] = in_data;
                            end else begin
                                phase_d[(sample_s-CP_LEN)*DATA_W +: DATA_W] = in_data;
                            end
                        end
                        if (at_last_s) begin
                            state_d = ST_HOLD;
                            wcnt_d  = '0;
                            cp_ok_d = cp_match(cpi_d, cpq_d, phase_d, quad_d);
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_COLLECT;
                    sym_count_d = sym_count_q + 8'd1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                wcnt_d  = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_COLLECT;
            wcnt_q      <= '0;
            phase_q     <= '0;
            quad_q      <= '0;
            cpi_q       <= '0;
            cpq_q       <= '0;
            cp_ok_q     <= 1'b0;
            frame_err_q <= 1'b0;
            sym_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            phase_q     <= phase_d;
            quad_q      <= quad_d;
            cpi_q       <= cpi_d;
            cpq_q       <= cpq_d;
            cp_ok_q     <= cp_ok_d;
            frame_err_q <= frame_err_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_HOLD);
    assign out_phase = phase_q;
    assign out_quad  = quad_q;
    assign cp_ok     = cp_ok_q;
    assign frame_err = frame_err_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_rx_cp_deserializer.sv
// Scoreboard bench for rx_cp_deserializer: frames are built as word arrays, the
// expected symbol is derived from the frame layout and checked by a separate monitor.
module tb_rx_cp_deserializer;

    localparam int DATA_W  = 16;
    localparam int N_FFT   = 8;
    localparam int CP_LEN  = 2;
    localparam int FRAME_W = 2 * (CP_LEN + N_FFT);
    localparam int VW      = N_FFT * DATA_W;

    typedef struct {
        logic [VW-1:0] ph;
        logic [VW-1:0] qd;
        logic          ok;
        logic [7:0]    sb;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [VW-1:0]       out_phase;
    logic [VW-1:0]       out_quad;
    logic                out_valid;
    logic                out_ready;
    logic                cp_ok;
    logic                frame_err;
    logic [7:0]          sym_count;

    int          total = 0;
    int          passed = 0;
    int          err_pend = 0;
    logic [7:0]  sym_model = 8'd0;
    exp_t        exp_q[$];
    logic [DATA_W-1:0] frame_w[FRAME_W];

    rx_cp_deserializer #(.DATA_W(DATA_W), .N_FFT(N_FFT), .CP_LEN(CP_LEN)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_phase(out_phase),
        .out_quad(out_quad), .out_valid(out_valid), .out_ready(out_ready),
        .cp_ok(cp_ok), .frame_err(frame_err), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        total++;
        $display("FAIL %s", nm);
    endtask

    // Expected symbol straight from the frame layout: sample s occupies words 2s (I), 2s+1 (Q).
    task automatic push_expected();
        exp_t e;
        e.ph = '0;
        e.qd = '0;
        e.ok = 1'b1;
        for (int k = 0; k < N_FFT; k++) begin
            e.ph[k*DATA_W +: DATA_W] = frame_w[2*(CP_LEN+k)];
            e.qd[k*DATA_W +: DATA_W] = frame_w[2*(CP_LEN+k)+1];
        end
        for (int j = 0; j < CP_LEN; j++) begin
            if (frame_w[2*j] != frame_w[2*(N_FFT+j)] || frame_w[2*j+1] != frame_w[2*(N_FFT+j)+1])
                e.ok = 1'b0;
        end
        e.sb = sym_model;
        sym_model = sym_model + 8'd1;
        exp_q.push_back(e);
    endtask

    task automatic build_fixed();
        for (int s = 0; s < CP_LEN + N_FFT; s++) begin
            int k;
            k = (s < CP_LEN) ? (N_FFT - CP_LEN + s) : (s - CP_LEN);
            frame_w[2*s]   = DATA_W'(k + 1);
            frame_w[2*s+1] = DATA_W'(-(k + 1));
        end
    endtask

    task automatic build_random(input bit good_cp);
        for (int i = 0; i < FRAME_W; i++) frame_w[i] = DATA_W'($urandom);
        if (good_cp) begin
            for (int j = 0; j < 2*CP_LEN; j++) frame_w[j] = frame_w[2*N_FFT + j];
        end
    endtask

    task automatic drive_word(input logic [DATA_W-1:0] d, input logic last);
        bit acc;
        int n;
        in_data = d; in_valid = 1'b1; in_last = last;
        acc = 1'b0; n = 0;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) fail_now("drive_timeout");
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input int stop_at, input bit last_on_stop, input bit gaps);
        for (int i = 0; i <= stop_at; i++) begin
            logic lst;
            int g;
            g = 0;
            while (gaps && ($urandom % 2 == 1) && g < 8) begin
                @(posedge clk); #1;
                g++;
            end
            lst = (i == stop_at) && last_on_stop;
            if (i == stop_at) begin
                if (stop_at == FRAME_W-1 && lst) push_expected();
                else if (lst || stop_at == FRAME_W-1) err_pend++;
            end
            drive_word(frame_w[i], lst);
        end
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        n = 0; done = 1'b0;
        while (!done && n < 600) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && in_ready && !out_valid;
            n++;
        end
        if (!done) fail_now("idle_timeout");
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_out_valid"}, VW'(out_valid), VW'(0));
        chk({nm, "_out_phase"}, out_phase, VW'(0));
        chk({nm, "_out_quad"}, out_quad, VW'(0));
        chk({nm, "_cp_ok"}, VW'(cp_ok), VW'(0));
        chk({nm, "_frame_err"}, VW'(frame_err), VW'(0));
        chk({nm, "_sym_count"}, VW'(sym_count), VW'(0));
        chk({nm, "_in_ready"}, VW'(in_ready), VW'(1));
    endtask

    // Monitor: pops the scoreboard on each new symbol and polices hold stability and error pulses.
    bit            prev_ov = 1'b0;
    bit            prev_fe = 1'b0;
    exp_t          cur;
    logic [VW-1:0] snap_ph, snap_qd;
    logic          snap_ok;
    always begin
        @(negedge clk);
        if (!reset) begin
            prev_ov = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_symbol");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("sym_phase", out_phase, cur.ph);
                        chk("sym_quad", out_quad, cur.qd);
                        chk("sym_cp_ok", VW'(cp_ok), VW'(cur.ok));
                        chk("sym_count_at_present", VW'(sym_count), VW'(cur.sb));
                    end
                    snap_ph = out_phase; snap_qd = out_quad; snap_ok = cp_ok;
                end else begin
                    chk("hold_phase", out_phase, snap_ph);
                    chk("hold_quad", out_quad, snap_qd);
                    chk("hold_cp_ok", VW'(cp_ok), VW'(snap_ok));
                end
                chk("hold_in_ready", VW'(in_ready), VW'(0));
            end
            if (frame_err) begin
                if (prev_fe) fail_now("frame_err_width");
                chk("frame_err_expected", VW'(err_pend > 0), VW'(1));
                if (err_pend > 0) err_pend--;
            end
            prev_ov = out_valid;
            prev_fe = frame_err;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Ramp frame with matching prefix; symbol visible right after the final word.
        build_fixed();
        send_frame(FRAME_W-1, 1'b1, 1'b0);
        chk("t1_latency_valid", VW'(out_valid), VW'(1));
        chk("t1_phase0", VW'(out_phase[15:0]), VW'(16'd1));
        chk("t1_phase7", VW'(out_phase[127:112]), VW'(16'd8));
        chk("t1_quad0", VW'(out_quad[15:0]), VW'(16'hFFFF));
        chk("t1_cp_ok", VW'(cp_ok), VW'(1));
        wait_idle();
        chk("t1_sym_count", VW'(sym_count), VW'(1));

        // Corrupted prefix I word.
        build_fixed();
        frame_w[0] = 16'h7FFF;
        send_frame(FRAME_W-1, 1'b1, 1'b0);
        chk("t2_cp_ok", VW'(cp_ok), VW'(0));
        wait_idle();

        // Early terminator, then missing terminator, each followed by a clean frame.
        build_random(1'b1);
        send_frame(11, 1'b1, 1'b0);
        chk("t3_no_valid", VW'(out_valid), VW'(0));
        build_random(1'b1);
        send_frame(FRAME_W-1, 1'b1, 1'b0);
        wait_idle();
        build_random(1'b1);
        send_frame(FRAME_W-1, 1'b0, 1'b0);
        build_random(1'b0);
        send_frame(FRAME_W-1, 1'b1, 1'b0);
        wait_idle();
        chk("t3_sym_count", VW'(sym_count), VW'(sym_model));

        // Back-pressure in hold while the next frame is already offered.
        out_ready = 1'b0;
        build_random(1'b1);
        send_frame(FRAME_W-1, 1'b1, 1'b0);
        build_random(1'b1);
        fork
            send_frame(FRAME_W-1, 1'b1, 1'b0);
        join_none
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t4_in_ready_stalled", VW'(in_ready), VW'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_still_hold", VW'(in_ready), VW'(0));
        @(negedge clk);
        chk("t4_in_ready_released", VW'(in_ready), VW'(1));
        @(posedge clk); #1;
        wait fork;
        wait_idle();

        // Random valid gaps over three frames.
        for (int f = 0; f < 3; f++) begin
            build_random(1'($urandom % 2));
            send_frame(FRAME_W-1, 1'b1, 1'b1);
        end
        wait_idle();
        chk("t5_sym_count", VW'(sym_count), VW'(sym_model));

        // Reset in the middle of a frame.
        build_random(1'b1);
        send_frame(9, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        exp_q.delete();
        err_pend = 0;
        sym_model = 8'd0;
        reset = 1'b1;
        build_random(1'b1);
        send_frame(FRAME_W-1, 1'b1, 1'b0);
        wait_idle();
        chk("t6_sym_count", VW'(sym_count), VW'(1));

        // 255 more symbols take the counter through 255 back to 0.
        for (int f = 0; f < 255; f++) begin
            build_random(1'($urandom % 2));
            send_frame(FRAME_W-1, 1'b1, 1'b0);
        end
        wait_idle();
        chk("wrap_sym_count", VW'(sym_count), VW'(0));

        chk("scoreboard_empty", VW'(exp_q.size()), VW'(0));
        chk("err_pending_zero", VW'(err_pend), VW'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
